// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared state encoding and default sizes for the register file dump reader.
package regfile_dump_pkg;
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_WIDTH = 5;
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every register address, streams each word out with its address and XORs them into a checksum.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
    state_t state;
    logic [ADDR_WIDTH-1:0] index;
    assign busy = state != IDLE;
    assign rd_addr = (state == IDLE) ? '0 : index;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            index <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
            done <= 1'b0;
            checksum <= '0;
        end else if (abort && state != IDLE) begin
            // abort outranks a same-edge handshake, so the held word is dropped
            state <= IDLE;
            out_valid <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        checksum <= '0;
                        index <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    out_data <= rd_data;
                    out_addr <= index;
                    out_valid <= 1'b1;
                    checksum <= checksum ^ rd_data;
                    state <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (index == LAST) begin
                            done <= 1'b1;
                            state <= DONE;
                        end else begin
                            index <= index + ADDR_WIDTH'(1);
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized dumps of a modelled register file, checked word by word against the array contents.
module tb_regfile_dump_reader;
    localparam int N = 32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic busy, out_valid, done;
    logic [4:0] rd_addr, out_addr;
    logic [31:0] rd_data, out_data, checksum;
    logic [31:0] regs [N];
    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .done(done), .checksum(checksum)
    );

    assign rd_data = regs[rd_addr];
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    function automatic logic [31:0] xor_upto(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r ^= regs[i];
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, 32'(out_addr), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    // One dump; stall_at/abort_at/rst_at select a word for backpressure, abort or async reset (-1 = none)
    task automatic dump(input int stall_at, input int stall_n, input int abort_at, input int rst_at);
        int t0;
        logic [31:0] held_d;
        logic [4:0] held_a;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = edge_cnt;
        check("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            step();
            check("word_valid", 32'(out_valid), 1);
            check("word_addr", 32'(out_addr), 32'(i));
            check("word_data", out_data, regs[i]);
            if (i == rst_at) begin
                #2 rst = 1'b0;
                #1 check_reset_outputs("async_rst");
                rst = 1'b1;
                step();
                check("after_rst_busy", 32'(busy), 0);
                return;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_valid", 32'(out_valid), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_checksum", checksum, xor_upto(i + 1));
                repeat (3) begin
                    step();
                    check("abort_no_done", 32'(done), 0);
                end
                return;
            end
            if (i == stall_at) begin
                held_d = out_data;
                held_a = out_addr;
                out_ready = 1'b0;
                repeat (stall_n) begin
                    step();
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_addr", 32'(out_addr), 32'(held_a));
                    check("stall_data", out_data, held_d);
                end
                out_ready = 1'b1;
            end
            if (i == 3) start = 1'b1;
            step();
            start = 1'b0;
            if (i < N - 1) check("no_early_done", 32'(done), 0);
        end
        check("done_pulse", 32'(done), 1);
        check("done_edge", 32'(edge_cnt - t0), 32'(2 * N + (stall_at >= 0 ? stall_n : 0)));
        check("final_checksum", checksum, xor_upto(N));
        step();
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("held_checksum", checksum, xor_upto(N));
    endtask

    initial begin
        for (int i = 0; i < N; i++) regs[i] = 32'h1000_0000 + 32'(i);
        repeat (2) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (10) begin
            step();
            check("idle_no_start", 32'(busy), 0);
        end
        dump(-1, 0, -1, -1);
        check("incr_checksum", checksum, 32'h0);
        for (int i = 0; i < N; i++) regs[i] = (i == 7) ? 32'hDEADBEEF : 32'h0;
        dump(-1, 0, -1, -1);
        check("beef_checksum_1", checksum, 32'hDEADBEEF);
        dump(-1, 0, -1, -1);
        check("beef_checksum_2", checksum, 32'hDEADBEEF);
        for (int i = 0; i < N; i++) regs[i] = $urandom;
        dump(5, 3, -1, -1);
        for (int i = 0; i < N; i++) regs[i] = $urandom;
        dump(-1, 0, 10, -1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_with_abort", 32'(busy), 1);
        check("restart_rd_addr", 32'(rd_addr), 0);
        step();
        check("restart_addr", 32'(out_addr), 0);
        check("restart_data", out_data, regs[0]);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) regs[i] = $urandom;
            dump(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), -1, -1);
        end
        for (int i = 0; i < N; i++) regs[i] = $urandom;
        dump(-1, 0, -1, 20);
        dump(-1, 0, -1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 32-entry register file. On a start pulse it walks every register address in order, reads each word through the register file's combinational read port, and presents each word with its address on a valid/ready output stream. It also accumulates an XOR checksum of all words read. It sits beside the register file as its reader, for debug dump and self-check, complementing the write-side driver.

## Interface
- DATA_WIDTH, 32, width of one register word
- NUM_REGS, 32, number of registers walked (addresses 0..NUM_REGS-1)
- ADDR_WIDTH, 5, width of the read address; must satisfy 2**ADDR_WIDTH >= NUM_REGS
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a dump in progress
- busy  out  1  high whenever the state is not IDLE
- rd_addr  out  ADDR_WIDTH  register file read address
- rd_data  in  DATA_WIDTH  register file read data, combinational from rd_addr
- out_valid  out  1  out_data and out_addr hold a word
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_WIDTH  captured register word
- out_addr  out  ADDR_WIDTH  address of out_data
- done  out  1  one-cycle pulse after the last word is accepted
- checksum  out  DATA_WIDTH  running XOR of all words captured in the current or last dump

## Operation
- Reset values: state IDLE, index 0, rd_addr 0, out_valid 0, out_data 0, out_addr 0, done 0, busy 0, checksum 0.
- Reset takes effect immediately when rst goes low, including mid-dump. No done pulse is produced. Release is synchronous to the next clk edge.
- States:
  - IDLE: rd_addr = 0. If start = 1 at an edge: checksum <= 0, index <= 0, go to READ.
  - READ: rd_addr = index. At the edge: out_data <= rd_data, out_addr <= index, out_valid <= 1, checksum <= checksum ^ rd_data, go to SEND.
  - SEND: out_valid, out_data and out_addr are held stable. At an edge with out_ready = 1: out_valid <= 0. If index == NUM_REGS-1, go to DONE; otherwise index <= index+1 and go to READ.
  - DONE: done = 1 for exactly one cycle, then go to IDLE. Checksum holds its final value until the next accepted start.
- abort = 1 at an edge in READ, SEND or DONE: go to IDLE and set out_valid <= 0. Checksum holds the partial value. No done pulse, and no new pulse if abort arrives in DONE, where the pulse is already in progress.
- abort has priority over an out_ready handshake at the same edge: the word is discarded.
- start in any state other than IDLE is ignored. start and abort together in IDLE: the start is accepted.
- The index never wraps past NUM_REGS-1. rd_addr is never driven to an out-of-range value.

## Timing
- Start sampled at edge 0: READ in cycle 0–1 (rd_addr = 0, busy = 1). out_valid rises after edge 1.
- With out_ready held high, each word takes 2 cycles: one in READ, one in SEND.
- A full dump of N words ends with the last handshake at edge 2N. done is high between edges 2N and 2N+1. busy falls after edge 2N+1.
- Backpressure: each cycle out_ready is low extends SEND by one cycle, with no loss or duplication.
- rd_data must settle within the READ cycle. Register file writes during a dump are visible if they complete before the corresponding READ cycle.

## Structure
- Package regfile_dump_pkg holds:
  - state encoding: IDLE, READ, SEND, DONE
  - default DATA_WIDTH / NUM_REGS / ADDR_WIDTH constants
- Single module. The FSM, index counter, output holding register and checksum are inline. No sub-module is warranted.

## Test plan
- Reset defaults: hold rst = 0 -> every output equals its reset value. Release rst and hold start = 0 for 10 cycles -> busy stays 0.
- Full dump, out_ready always 1, reg[i] = 32'h1000_0000 + i:
  - 32 words in address order 0..31, each with out_data = 32'h1000_0000 + out_addr
  - done pulse at edge 64 after start
  - checksum 32'h0000_0000
- Checksum: all registers 0 except reg[7] = 32'hDEADBEEF -> final checksum 32'hDEADBEEF. A second dump gives the same value, not accumulated.
- Backpressure: out_ready low for 3 cycles on word 5 -> out_data and out_addr stay stable (addr 5) for 4 cycles. No word is skipped or repeated, and done is delayed by 3 cycles.
- Abort at word 10 while SEND -> after the next edge out_valid = 0 and busy = 0, with no done pulse. start during the dump is ignored. A new start dumps from address 0 again.
- Async reset mid-dump, rst low between clock edges at word 20 -> outputs go to reset values immediately, without waiting for a clk edge.
